// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width default, FSM state encodings and counter sizing for the divider
package alu_pkg;

   localparam int WIDTH_DEF = 16;

   // FSM state encodings
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // bit iteration counter width: log2(width)+1
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/alu_div_step.sv
// rtl/alu_div_step.sv - one restoring shift-subtract step of an unsigned divider
module alu_div_step
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] partial;
   logic [WIDTH:0] diff;
   logic           take;

   // shift in the next dividend bit, subtract the divisor if it fits, otherwise restore
   always_comb begin
      partial = {rem_in[WIDTH-1:0], bit_in};
      diff    = partial - {1'b0, divisor};
      // a set top bit would be shifted out, so the shifted value certainly exceeds the divisor
      take    = rem_in[WIDTH] | (partial >= {1'b0, divisor});
      rem_out = take ? diff : partial;
      q_bit   = take;
   end

endmodule

// File: rtl/alu_div16.sv
// rtl/alu_div16.sv - multi-cycle unsigned restoring divider with start/busy/done handshake
module alu_div16
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem_r;     // partial remainder
   logic [WIDTH-1:0] dvd_r;     // dividend bits shift out of the top, quotient bits shift in at the bottom
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH:0]   step_rem;
   logic             step_q;
   logic             accept;

   alu_div_step #(
      .WIDTH   (WIDTH)
   ) u_step (
      .rem_in  (rem_r),
      .bit_in  (dvd_r[WIDTH-1]),
      .divisor (dvs_r),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // handshake outputs decode straight from the state so they cannot drift from it
   always_comb begin
      busy   = (state == RUN);
      done   = (state == DONE);
      accept = start && ((state == IDLE) || (state == DONE));
   end

   // sequencing, iteration and result registers; results only move on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rem_r       <= '0;
         dvd_r       <= '0;
         dvs_r       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  if (divisor == '0) begin
                     // no iteration needed: report immediately
                     state       <= DONE;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= RUN;
                     cnt   <= '0;
                     rem_r <= '0;
                     dvd_r <= dividend;
                     dvs_r <= divisor;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               rem_r <= step_rem;
               dvd_r <= {dvd_r[WIDTH-2:0], step_q};
               if (cnt == LAST) begin
                  state       <= DONE;
                  quotient    <= {dvd_r[WIDTH-2:0], step_q};
                  remainder   <= step_rem[WIDTH-1:0];
                  div_by_zero <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_div16.md
ALU_DIV16 -- requirements
Module: alu_div16

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request a new division; accepted only when busy=0.
REQ-005 The module SHALL have port dividend, input, WIDTH bits: unsigned dividend, sampled on the accepting edge.
REQ-006 The module SHALL have port divisor, input, WIDTH bits: unsigned divisor, sampled on the accepting edge.
REQ-007 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse marking the cycle in which results first become valid.
REQ-009 The module SHALL have port quotient, output, WIDTH bits: unsigned quotient.
REQ-010 The module SHALL have port remainder, output, WIDTH bits: unsigned remainder.
REQ-011 The module SHALL have port div_by_zero, output, 1 bit: set when the last accepted divisor was 0.

Function
REQ-012 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE with start=1, the module SHALL latch the operands and enter RUN; cycle 0 is the accepting cycle.
REQ-014 RUN SHALL last exactly WIDTH cycles (cycles 1..16); each cycle SHALL perform one restoring shift-subtract step from MSB to LSB with a WIDTH+1-bit partial remainder.
REQ-015 After the last RUN cycle, the module SHALL enter DONE for exactly one cycle (cycle 17), with done=1 and busy=0, and return to IDLE unless start=1.
REQ-016 busy SHALL be 1 exactly when the state is RUN.
REQ-017 If start=1 while busy=1, the module SHALL ignore it and leave the operands and progress unchanged.
REQ-018 start=1 in the DONE cycle SHALL be accepted (back-to-back operation), so done for the new operation falls 17 cycles later.
REQ-019 A zero divisor SHALL skip RUN and go to DONE in cycle 1, with quotient=all ones, remainder=dividend and div_by_zero=1.
REQ-020 For a nonzero divisor, the results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, and div_by_zero SHALL be 0.
REQ-021 quotient, remainder and div_by_zero SHALL update only in the cycle done=1 and then hold until the next done; intermediate values SHALL NOT be visible on the outputs.

Reset
REQ-022 When rst=1 at a clock edge, the state SHALL become IDLE and busy, done, quotient, remainder and div_by_zero SHALL become 0.
REQ-023 rst SHALL take priority over start.
REQ-024 A reset during RUN SHALL abort the operation without a done pulse.
REQ-025 After rst deasserts, start SHALL be accepted on the first edge.

Structure
REQ-026 The WIDTH default and the state enumeration (IDLE, RUN, DONE) SHALL live in the shared package alu_pkg.
REQ-027 One step of the restoring algorithm SHALL be a combinational sub-module named alu_div_step.
- Inputs: partial remainder, next dividend bit, divisor.
- Outputs: new partial remainder and quotient bit.
- The bit iteration counter SHALL be log2(WIDTH)+1 bits wide.

Verification
REQ-028 100/7 -> done in cycle 17, quotient=14, remainder=2, div_by_zero=0.
REQ-029 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0; 3/10 -> quotient=0, remainder=3.
REQ-030 5/0 -> done in cycle 1, quotient=16'hFFFF, remainder=5, div_by_zero=1.
REQ-031 Start 1000/3, then start 9/9 in cycle 5 -> second request ignored, done in cycle 17 with quotient=333 and remainder=1.
REQ-032 Start 1000/3, then start 50/6 in the DONE cycle -> second done 17 cycles later with quotient=8 and remainder=2.
REQ-033 rst in cycle 8 of a run -> no done pulse, all outputs 0, and the next start completes normally.
